// File: rtl/board_tx_pkg.sv
// Shared types and constants for the board word UART framer.
// Frame length depends on the optional checksum byte (macro BOARD_TX_CHECKSUM_EN).
package board_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      STROBE,
      WAIT_HI,
      WAIT_LO
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         FRAME_LEN_BASE    = 3;
   localparam int         FRAME_LEN_CSUM    = 4;

endpackage

// File: rtl/board_tx_framer.sv
// Frames a 16-bit board word as SYNC, hi, lo (and checksum when BOARD_TX_CHECKSUM_EN
// is defined) and hands the bytes one at a time to a UART transmitter.
module board_tx_framer
   import board_tx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int         BUSY_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_word,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  tx_data,
   output logic        tx_stb,
   input  logic        tx_busy,
   output logic        frame_done
);

`ifdef BOARD_TX_CHECKSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

   localparam int                WAIT_W    = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);
   localparam logic [1:0]        LAST_IDX  = 2'(FRAME_LEN - 1);

   state_t            state;
   state_t            state_next;
   logic [15:0]       word_q;
   logic [1:0]        byte_idx;
   logic [WAIT_W-1:0] wait_cnt;
   logic [7:0]        byte_sel;
   logic              accept;
   logic              last_byte;
   logic              wait_expired;
   logic              byte_released;

   assign in_ready      = (state == IDLE);
   assign tx_stb        = (state == STROBE);
   assign accept        = in_valid && in_ready;
   assign last_byte     = (byte_idx == LAST_IDX);
   assign wait_expired  = (wait_cnt == WAIT_LAST);
   assign byte_released = (state == WAIT_LO) && !tx_busy;

   // NOTE: every variable gets a value before the case so no path can infer a latch.
   always_comb begin
      byte_sel = SYNC_BYTE;
      case (byte_idx)
         2'd1:    byte_sel = word_q[15:8];
         2'd2:    byte_sel = word_q[7:0];
`ifdef BOARD_TX_CHECKSUM_EN
         2'd3:    byte_sel = SYNC_BYTE ^ word_q[15:8] ^ word_q[7:0];
`endif
         default: byte_sel = SYNC_BYTE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid) state_next = ARM;
         ARM:     if (!tx_busy) state_next = STROBE;
         STROBE:  state_next = WAIT_HI;
         // A transmitter that never raises busy must not stall the frame.
         WAIT_HI: if (tx_busy || wait_expired) state_next = WAIT_LO;
         WAIT_LO: if (!tx_busy) state_next = last_byte ? IDLE : ARM;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q     <= '0;
         byte_idx   <= '0;
         wait_cnt   <= '0;
         tx_data    <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         frame_done <= byte_released && last_byte;

         if (accept)
            byte_idx <= '0;
         else if (byte_released && !last_byte)
            byte_idx <= byte_idx + 2'd1;

         if (accept)
            word_q <= in_word;

         // Loaded on the ARM->STROBE edge, so the byte is stable for the whole handshake.
         if (state == ARM && !tx_busy)
            tx_data <= byte_sel;

         if (state == WAIT_HI) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                  wait_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_board_tx_framer.sv
// Scoreboard bench for board_tx_framer: stimulus pushes expected bytes, a monitor checks
// every strobe and frame_done against a behavioural UART model (honours BOARD_TX_CHECKSUM_EN).
module tb_board_tx_framer;

   localparam int         BUSY_WAIT = 4;
   localparam logic [7:0] SYNC      = 8'hA5;
`ifdef BOARD_TX_CHECKSUM_EN
   localparam int N = 4;
`else
   localparam int N = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_word;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  tx_data;
   logic        tx_stb;
   logic        tx_busy;
   logic        frame_done;

   logic uart_busy = 1'b0;
   logic hold_busy = 1'b0;
   assign tx_busy = uart_busy | hold_busy;

   always #5 clk = ~clk;

   board_tx_framer #(
      .SYNC_BYTE (SYNC),
      .BUSY_WAIT (BUSY_WAIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_word    (in_word),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_data    (tx_data),
      .tx_stb     (tx_stb),
      .tx_busy    (tx_busy),
      .frame_done (frame_done)
   );

   int         checks      = 0;
   int         failures    = 0;
   int         cyc         = 0;
   logic [7:0] exp_q[$];
   int         frames_exp  = 0;
   int         frames_seen = 0;
   int         stb_in_frame = 0;
   int         acc_cyc     = 0;
   int         last_stb    = 0;
   logic [7:0] last_byte   = 8'h00;
   int         rv_count    = 0;
   bit         lat_chk     = 1'b1;
   bit         never_rise  = 1'b0;
   bit         uart_rand   = 1'b0;
   int         uart_dly    = 1;
   int         uart_hold   = 10;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference frame: sync, high byte, low byte, and XOR checksum of the three when enabled.
   function automatic void push_frame(input logic [15:0] w);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'(w >> 8);
      lo = 8'(w & 16'h00FF);
      exp_q.push_back(SYNC);
      exp_q.push_back(hi);
      exp_q.push_back(lo);
      if (N == 4) exp_q.push_back(SYNC ^ hi ^ lo);
      frames_exp++;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART transmitter model: busy rises some cycles after a strobe and holds for a while.
   initial begin
      int pend;
      int hold;
      pend = 0;
      hold = 0;
      forever begin
         @(negedge clk);
         if (pend > 0) begin
            pend--;
            if (pend == 0) uart_busy = 1'b1;
         end else if (uart_busy) begin
            hold--;
            if (hold <= 0) uart_busy = 1'b0;
         end
         if (tx_stb && !never_rise && !rst) begin
            pend = uart_rand ? $urandom_range(1, 3) : uart_dly;
            hold = uart_rand ? $urandom_range(1, 8) : uart_hold;
         end
      end
   end

   // Monitor: pops the expected byte on every strobe and checks frame boundaries.
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
         if (in_valid && in_ready) rv_count++;
         if (tx_stb) begin
            check("stb_while_busy", 32'(tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_stb", 32'd1, 32'd0);
            end else begin
               last_byte = exp_q.pop_front();
               check("tx_byte", 32'(tx_data), 32'(last_byte));
            end
            if (stb_in_frame == 0 && lat_chk)
               check("first_stb_latency", 32'(cyc - acc_cyc), 32'd2);
            if (never_rise && stb_in_frame > 0)
               check("timeout_gap", 32'((cyc - last_stb >= BUSY_WAIT + 2) &&
                                        (cyc - last_stb <= BUSY_WAIT + 4)), 32'd1);
            last_stb = cyc;
            stb_in_frame++;
         end else if (tx_busy && !hold_busy && stb_in_frame > 0) begin
            check("tx_data_stable", 32'(tx_data), 32'(last_byte));
         end
         if (frame_done) begin
            check("bytes_per_frame", 32'(stb_in_frame), 32'(N));
            stb_in_frame = 0;
            frames_seen++;
         end
      end
   end

   // Called at a falling edge; returns one falling edge after the word is accepted.
   task automatic send(input logic [15:0] w, input bit keep);
      int n;
      in_word  = w;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      push_frame(w);
      acc_cyc = cyc;
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", 32'(exp_q.size() == 0 && in_ready), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_word  = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_tx_stb", 32'(tx_stb), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Busy rises one cycle after each strobe and holds ten cycles.
      send(16'h1234, 1'b0);
      drain();
      send(16'hAAAA, 1'b0);
      drain();

      // Transmitter busy at accept: no strobe until it falls.
      lat_chk   = 1'b0;
      hold_busy = 1'b1;
      @(negedge clk);
      send(16'($urandom), 1'b0);
      repeat (20) @(negedge clk);
      check("held_busy_no_stb", 32'(stb_in_frame), 32'd0);
      hold_busy = 1'b0;
      drain();
      lat_chk = 1'b1;

      // Transmitter never raises busy: every byte advances on the timeout.
      never_rise = 1'b1;
      send(16'($urandom), 1'b0);
      drain();
      send(16'h00FF, 1'b0);
      drain();
      never_rise = 1'b0;

      // Asynchronous reset in the middle of the second byte.
      send(16'($urandom), 1'b0);
      n = 0;
      while (stb_in_frame < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_byte2", 32'(stb_in_frame), 32'd2);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_tx_stb", 32'(tx_stb), 32'd0);
      check("mid_rst_tx_data", 32'(tx_data), 32'h00);
      check("mid_rst_frame_done", 32'(frame_done), 32'd0);
      exp_q.delete();
      frames_exp--;
      stb_in_frame = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      send(16'h0F0F, 1'b0);
      drain();

      // Randomized words and transmitter timing.
      uart_rand = 1'b1;
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(16'($urandom), 1'b0);
      end
      drain();

      // in_valid held high: back-to-back frames, one accept per frame.
      r0 = rv_count;
      for (int i = 0; i < 5; i++) send(16'($urandom), 1'b1);
      in_valid = 1'b0;
      drain();
      check("accepts_b2b", 32'(rv_count - r0), 32'd5);

      check("frames_done_total", 32'(frames_seen), 32'(frames_exp));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/board_tx_framer.md
BOARD_TX_FRAMER -- requirements
Module: board_tx_framer

Interface
REQ-001 SHALL provide parameter SYNC_BYTE, default 8'hA5, meaning the first byte of every frame.
REQ-002 SHALL provide parameter BUSY_WAIT, default 4, meaning the maximum number of cycles after a strobe to wait for tx_busy to rise.
REQ-003 SHALL provide port clk, input, 1 bit: 100 MHz system clock; the block uses one clock.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL provide port in_word, input, 16 bits: board word to transmit.
REQ-006 SHALL provide port in_valid, input, 1 bit: in_word is valid.
REQ-007 SHALL provide port in_ready, output, 1 bit: the block can accept a word.
REQ-008 SHALL provide port tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-009 SHALL provide port tx_stb, output, 1 bit: one-cycle send strobe to the UART transmitter.
REQ-010 SHALL provide port tx_busy, input, 1 bit: busy flag from the UART transmitter.
REQ-011 SHALL provide port frame_done, output, 1 bit: one-cycle pulse after the last byte of a frame completes.

Function
REQ-012 SHALL capture in_word into an internal register on a cycle where in_valid and in_ready are both high.
REQ-013 SHALL drive in_ready high only in state IDLE.
REQ-014 SHALL send the frame bytes in this order: SYNC_BYTE, in_word[15:8], in_word[7:0], then the checksum byte when it is enabled (REQ-027).
REQ-015 SHALL implement these states: IDLE, ARM, STROBE, WAIT_HI, WAIT_LO.
REQ-016 SHALL make these transitions:
- IDLE goes to ARM on accept.
- ARM goes to STROBE when tx_busy is low.
- STROBE lasts exactly 1 cycle and then goes to WAIT_HI.
REQ-017 SHALL handle WAIT_HI as follows:
- Go to WAIT_LO when tx_busy is high.
- Go to WAIT_LO after BUSY_WAIT cycles if tx_busy never rises; the byte is then treated as sent.
REQ-018 SHALL handle WAIT_LO as follows:
- When tx_busy is low and bytes remain, increment the byte index and go to ARM.
- When tx_busy is low and the last byte is done, go to IDLE and pulse frame_done.
REQ-019 SHALL assert tx_stb only in STROBE, never while tx_busy is high, and for exactly 1 cycle per byte.
REQ-020 SHALL hold tx_data stable from the STROBE cycle until the block leaves WAIT_LO.
REQ-021 SHALL use a 2-bit byte index that runs 0 to N-1, where N is 3 or 4, and SHALL never wrap within a frame.
REQ-022 SHALL give the first strobe a latency of 2 cycles after accept when tx_busy is low (accept, then ARM, then STROBE).
REQ-023 SHALL hold in ARM, without a strobe, when tx_busy is high at the time of ARM.
REQ-024 SHALL ignore in_valid while a frame is in flight; no word is dropped, because in_ready is low.
REQ-025 SHALL allow frame_done and a new accept on the same cycle as the return to IDLE, with in_ready high in that IDLE cycle.

Reset
REQ-026 SHALL, when rst is asserted asynchronously, including mid-frame, force:
- state IDLE
- byte index 0
- tx_stb 0
- tx_data 8'h00
- frame_done 0
- in_ready 1 after rst deasserts
- the partial frame aborted, with no further strobes.

Configuration
REQ-027 SHALL support macro BOARD_TX_CHECKSUM_EN with this behaviour:
- Defined: append a fourth byte equal to SYNC_BYTE ^ in_word[15:8] ^ in_word[7:0], so N = 4.
- Undefined: send 3-byte frames and synthesize no checksum logic.

Structure
REQ-028 SHALL place in shared package board_tx_pkg:
- the state enum type
- the default SYNC_BYTE constant
- the frame length constants (3 and 4).
REQ-029 SHALL be a single module with no sub-module, since the byte mux and checksum are trivial inline logic.

Verification
REQ-030 SHALL cover this scenario: checksum enabled, in_word=16'h1234, tx_busy rising 1 cycle after each strobe and held for 10 cycles -> bytes A5, 12, 34, 83, then one frame_done pulse.
REQ-031 SHALL cover this scenario: checksum disabled, in_word=16'hAAAA -> bytes A5, AA, AA; exactly 3 strobes; frame_done after the third.
REQ-032 SHALL cover this scenario: tx_busy held high for 20 cycles at accept -> no strobe until tx_busy falls, then byte A5.
REQ-033 SHALL cover this scenario: tx_busy never rises -> each byte advances after BUSY_WAIT=4 cycles, and all bytes are strobed.
REQ-034 SHALL cover this scenario: rst asserted during byte 2 -> tx_stb stays 0, in_ready=1; the next word 16'h0F0F starts a fresh frame at A5.
REQ-035 SHALL cover this scenario: in_valid held high continuously -> back-to-back frames with no lost words; in_ready pulses once per frame.
